div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Initiator-side controller for the multi-cycle divider's `div`/`complete` handshake. It accepts divide requests from the execute stage and registers and holds the operands. It drives `div` until `complete`, then captures quotient and remainder and presents them to writeback on a valid/ready port. It also resolves divide-by-zero locally, supports pipeline flush, and aborts a hung divider after a bounded number of cycles.

## Interface
- `TAG_W`, 5: width of the request tag carried to the result (destination register id).
- `TIMEOUT`, 34: maximum number of cycles `div` stays high before abort; legal range 2..63.
- `div_clk`  in  1  clock; all logic on its rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  divide request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_signed`  in  1  1 = signed divide, 0 = unsigned divide.
- `req_x`, `req_y`  in  32  dividend and divisor.
- `req_tag`  in  TAG_W  opaque tag.
- `flush`  in  1  discard the in-flight request and any pending result.
- `div`  out  1  divider start/hold; high from issue until the `complete` cycle.
- `div_signed`  out  1  registered operand to the divider.
- `div_x`, `div_y`  out  32  registered operands to the divider.
- `div_complete`  in  1  divider result valid; meaningful only while `div` = 1.
- `div_s`, `div_r`  in  32  divider quotient and remainder.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  writeback accepts the result.
- `res_s`, `res_r`  out  32  quotient and remainder.
- `res_tag`  out  TAG_W  tag of the request that produced the result.
- `res_timeout`  out  1  1 = result produced by abort; `res_s` = `res_r` = 0.

## Operation
- FSM states: IDLE, RUN, DRAIN, RESP.
- `req_ready` = (state == IDLE) && `resetn` && !`flush`.
- **IDLE, accept with `req_y` != 0:** latch `div_signed`/`div_x`/`div_y`/`res_tag`, set `div` = 1, clear the timeout counter, go to RUN.
- **IDLE, accept with `req_y` == 0 (divide-by-zero):** `div` stays 0. Load `res_s` = 0xFFFFFFFF, `res_r` = `req_x`, `res_timeout` = 0, `res_valid` = 1; go to RESP. This applies to both signed and unsigned requests.
- **RUN:**
  - If `div_complete`: capture `div_s`/`div_r` into `res_s`/`res_r`, set `res_timeout` = 0, `res_valid` = 1, `div` = 0, go to RESP.
  - Else if the counter == `TIMEOUT`-1: set `res_s` = `res_r` = 0, `res_timeout` = 1, `res_valid` = 1, `div` = 0, go to RESP.
  - Else increment the counter.
- **RUN with `flush`:**
  - If `div_complete` in the same cycle: drop the result, `div` = 0, go to IDLE.
  - Otherwise go to DRAIN; `div` stays high and the operands stay stable.
- **DRAIN:** on `div_complete` or timeout expiry, set `div` = 0 and go to IDLE with no result. `flush` is ignored in this state.
- **RESP:**
  - On `res_ready`, or on `flush`: `res_valid` = 0, go to IDLE.
  - `res_*` stay stable while `res_valid` = 1 and `res_ready` = 0.
- **Divider-facing operands:** held constant whenever `div` = 1. Whenever `div` = 0 outside a latch cycle, they are forced to idle values: `div_signed` = 0, `div_x` = 0, `div_y` = 1.
- **Arithmetic:** none besides the counter. The signed overflow case (0x80000000 / -1) is passed through to the divider unmodified.

## Timing
- **Reset** (`resetn` = 0 at a clock edge): state = IDLE, `div` = 0, `div_signed` = 0, `div_x` = 0, `div_y` = 1, `res_valid` = 0, `res_s` = `res_r` = 0, `res_tag` = 0, `res_timeout` = 0, counter = 0.
  - Reset mid-RUN deasserts `div` on the following cycle. No result is produced.
- **Normal issue:** accept at edge N, so `div` = 1 from N+1.
  - If `div_complete` is sampled high at edge M, then `res_valid` = 1 and `div` = 0 from M+1.
  - Minimum accept-to-result latency is 2 cycles.
- **Divide-by-zero:** accept at N gives `res_valid` = 1 from N+1. `div` never rises.
- **Timeout:** `div` is high for at most `TIMEOUT` cycles. If `complete` has not arrived, `res_valid` rises on the cycle after the `TIMEOUT`-th high cycle.
- **Back-to-back:** a result handshake at edge K gives IDLE from K+1, so the next accept is possible at edge K+1. There is one request in flight at most.
- **`div_complete` while `div` = 0:** ignored.
- **`flush` with `req_valid` in IDLE:** the request is not accepted.

## Test plan
- Unsigned 100/7, `res_ready` = 1, stub completes after 10 cycles -> `res_s` = 14, `res_r` = 2, `res_valid` high exactly 1 cycle, `div` high exactly 10 cycles.
- Signed x = 0xFFFFFFF9, y = 2, tag = 3 -> `res_s` = 0xFFFFFFFD, `res_r` = 0xFFFFFFFF, `res_tag` = 3; `div_x`/`div_y` stable for the whole time `div` is high.
- y = 0, x = 0x1234 -> `div` never rises; `res_valid` 1 cycle after accept with `res_s` = 0xFFFFFFFF, `res_r` = 0x1234.
- `res_ready` held low 5 cycles after the result -> `res_*` unchanged and `req_ready` = 0 throughout; one cycle after `res_ready` rises, a new request is accepted.
- `flush` on the 3rd RUN cycle, stub completes 4 cycles later -> `div` stays high until that `complete`, no `res_valid`, `req_ready` = 1 the cycle after.
- Stub never completes, `TIMEOUT` = 34 -> `div` high exactly 34 cycles, then `res_valid` = 1, `res_timeout` = 1, `res_s` = `res_r` = 0; the next request proceeds normally.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Sits on the initiator side of the multi-cycle divider and manages its
//   div/complete handshake.
//   - Accepts one divide request at a time from execute. The operands are
//     registered and held steady toward the divider while div is high.
//   - Divide-by-zero is resolved locally and never starts the divider.
//   - A hung divider is aborted after TIMEOUT high cycles of div.
//   - The result is presented to writeback on a valid/ready port.
// Ports:
//   div_clk, resetn                    clock, synchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_signed, req_x, req_y, req_tag  request payload
//   flush                              drop the in-flight request or pending result
//   div, div_signed, div_x, div_y      divider start/hold and operands
//   div_complete, div_s, div_r         divider completion and results
//   res_valid/res_ready                result handshake
//   res_s, res_r, res_tag, res_timeout result payload
module div_issue_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 34
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             div,
  output logic             div_signed,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic             div_complete,
  input  logic [31:0]      div_s,
  input  logic [31:0]      div_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_s,
  output logic [31:0]      res_r,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} state_t;

  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             div_d, div_signed_d;
  logic [31:0]      div_x_d, div_y_d;
  logic             res_valid_d, res_timeout_d;
  logic [31:0]      res_s_d, res_r_d;
  logic [TAG_W-1:0] res_tag_d;
  logic             expire;
  logic             release_div;

  assign req_ready = (state_q == S_IDLE) && resetn && !flush;
  assign expire    = (cnt_q == TO_LAST);

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div         <= 1'b0;
      div_signed  <= 1'b0;
      div_x       <= '0;
      div_y       <= 32'd1;
      res_valid   <= 1'b0;
      res_s       <= '0;
      res_r       <= '0;
      res_tag     <= '0;
      res_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div         <= div_d;
      div_signed  <= div_signed_d;
      div_x       <= div_x_d;
      div_y       <= div_y_d;
      res_valid   <= res_valid_d;
      res_s       <= res_s_d;
      res_r       <= res_r_d;
      res_tag     <= res_tag_d;
      res_timeout <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div;
    div_signed_d  = div_signed;
    div_x_d       = div_x;
    div_y_d       = div_y;
    res_valid_d   = res_valid;
    res_s_d       = res_s;
    res_r_d       = res_r;
    res_tag_d     = res_tag;
    res_timeout_d = res_timeout;
    release_div   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          res_tag_d = req_tag;
          if (req_y != '0) begin
            div_d        = 1'b1;
            div_signed_d = req_signed;
            div_x_d      = req_x;
            div_y_d      = req_y;
            cnt_d        = '0;
            state_d      = S_RUN;
          end else begin
            res_s_d       = '1;
            res_r_d       = req_x;
            res_timeout_d = 1'b0;
            res_valid_d   = 1'b1;
            state_d       = S_RESP;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          // A flush that coincides with completion or with the last allowed
          // cycle releases the divider at once; otherwise wait in DRAIN so
          // the divider sees stable operands until it finishes.
          if (div_complete || expire) begin
            release_div = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 6'd1;
            state_d = S_DRAIN;
          end
        end else if (div_complete) begin
          res_s_d       = div_s;
          res_r_d       = div_r;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          release_div   = 1'b1;
          state_d       = S_RESP;
        end else if (expire) begin
          res_s_d       = '0;
          res_r_d       = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          release_div   = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_DRAIN: begin
        if (div_complete || expire) begin
          release_div = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_RESP: begin
        if (res_ready || flush) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Operands return to their idle values whenever the divider is released.
    if (release_div) begin
      div_d        = 1'b0;
      div_signed_d = 1'b0;
      div_x_d      = '0;
      div_y_d      = 32'd1;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int unsigned TAG_W = 5;

  logic             div_clk = 1'b0;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [31:0]      req_x, req_y;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             div;
  logic             div_signed;
  logic [31:0]      div_x, div_y;
  logic             div_complete;
  logic [31:0]      div_s, div_r;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_s, res_r;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;

  int total = 0;
  int bad   = 0;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(34)) dut (
    .div_clk(div_clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
    .div(div), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_complete(div_complete), .div_s(div_s), .div_r(div_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_r(res_r),
    .res_tag(res_tag), .res_timeout(res_timeout)
  );

  always #5 div_clk = ~div_clk;

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic sg, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tag);
    req_signed = sg; req_x = x; req_y = y; req_tag = tag; req_valid = 1'b1;
    chk("req_ready before accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Divider stub: counts high cycles of div, completes on the lat-th one
  // (lat = 0 never completes), and counts operand changes while div is high.
  task automatic serve(input int lat, input logic [31:0] s, input logic [31:0] r,
                       input logic [31:0] xe, input logic [31:0] ye,
                       output int highs, output int op_err);
    highs = 0;
    op_err = 0;
    for (int i = 0; i < 100; i++) begin
      if (div !== 1'b1) break;
      highs++;
      if (div_x !== xe || div_y !== ye) op_err++;
      if (highs == lat) begin
        div_complete = 1'b1; div_s = s; div_r = r;
      end
      tick();
      div_complete = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, op_err, errs;

    resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_x = '0; req_y = '0;
    req_tag = '0; flush = 1'b0; div_complete = 1'b0; div_s = '0; div_r = '0;
    res_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst div", 32'(div), 32'd0);
    chk("rst div_x", div_x, 32'd0);
    chk("rst div_y", div_y, 32'd1);
    chk("rst div_signed", 32'(div_signed), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_s", res_s, 32'd0);
    chk("rst res_r", res_r, 32'd0);
    chk("rst res_tag", 32'(res_tag), 32'd0);
    chk("rst res_timeout", 32'(res_timeout), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("idle req_ready", 32'(req_ready), 32'd1);

    // Unsigned 100/7, 10-cycle divider
    res_ready = 1'b1;
    issue(1'b0, 32'd100, 32'd7, 5'd1);
    chk("t1 div rises", 32'(div), 32'd1);
    chk("t1 req_ready busy", 32'(req_ready), 32'd0);
    chk("t1 div_signed", 32'(div_signed), 32'd0);
    serve(10, 32'd14, 32'd2, 32'd100, 32'd7, highs, op_err);
    chk("t1 div high cycles", highs, 32'd10);
    chk("t1 res_valid", 32'(res_valid), 32'd1);
    chk("t1 res_s", res_s, 32'd14);
    chk("t1 res_r", res_r, 32'd2);
    chk("t1 res_tag", 32'(res_tag), 32'd1);
    chk("t1 res_timeout", 32'(res_timeout), 32'd0);
    chk("t1 div_x idle", div_x, 32'd0);
    chk("t1 div_y idle", div_y, 32'd1);
    tick();
    chk("t1 res_valid one cycle", 32'(res_valid), 32'd0);
    chk("t1 req_ready after", 32'(req_ready), 32'd1);

    // Signed -7/2
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd3);
    chk("t2 div_signed", 32'(div_signed), 32'd1);
    serve(5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2, highs, op_err);
    chk("t2 div high cycles", highs, 32'd5);
    chk("t2 operands stable", op_err, 32'd0);
    chk("t2 res_s", res_s, 32'hFFFF_FFFD);
    chk("t2 res_r", res_r, 32'hFFFF_FFFF);
    chk("t2 res_tag", 32'(res_tag), 32'd3);
    chk("t2 div_signed idle", 32'(div_signed), 32'd0);
    tick();

    // Divide by zero
    issue(1'b0, 32'h1234, 32'd0, 5'd7);
    chk("t3 div stays low", 32'(div), 32'd0);
    chk("t3 res_valid", 32'(res_valid), 32'd1);
    chk("t3 res_s", res_s, 32'hFFFF_FFFF);
    chk("t3 res_r", res_r, 32'h1234);
    chk("t3 res_tag", 32'(res_tag), 32'd7);
    chk("t3 div_x idle", div_x, 32'd0);
    tick();
    chk("t3 res_valid drop", 32'(res_valid), 32'd0);
    chk("t3 div still low", 32'(div), 32'd0);

    // Backpressure, then back-to-back with minimum latency
    res_ready = 1'b0;
    issue(1'b0, 32'd50, 32'd5, 5'd4);
    serve(3, 32'd10, 32'd0, 32'd50, 32'd5, highs, op_err);
    req_signed = 1'b0; req_x = 32'd9; req_y = 32'd2; req_tag = 5'd5; req_valid = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_s !== 32'd10 || res_r !== 32'd0 ||
          res_tag !== 5'd4 || req_ready !== 1'b0 || div !== 1'b0) errs++;
      tick();
    end
    chk("t4 hold stable", errs, 32'd0);
    res_ready = 1'b1;
    tick();
    chk("t4 res_valid dropped", 32'(res_valid), 32'd0);
    chk("t4 req_ready next", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t4 new accept", 32'(div), 32'd1);
    chk("t4 new div_x", div_x, 32'd9);
    serve(1, 32'd4, 32'd1, 32'd9, 32'd2, highs, op_err);
    chk("t4 min latency highs", highs, 32'd1);
    chk("t4 res_s", res_s, 32'd4);
    chk("t4 res_tag", 32'(res_tag), 32'd5);
    tick();

    // Flush on 3rd RUN cycle, divider completes 4 cycles later
    issue(1'b0, 32'd20, 32'd3, 5'd6);
    tick(); tick();
    flush = 1'b1;
    #1;
    chk("t5 req_ready flush", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (div !== 1'b1 || res_valid !== 1'b0 || div_x !== 32'd20 || div_y !== 32'd3) errs++;
      if (i == 3) begin div_complete = 1'b1; div_s = 32'd6; div_r = 32'd2; end
      tick();
      div_complete = 1'b0;
    end
    chk("t5 drain hold", errs, 32'd0);
    chk("t5 div released", 32'(div), 32'd0);
    chk("t5 no result", 32'(res_valid), 32'd0);
    chk("t5 req_ready after", 32'(req_ready), 32'd1);
    chk("t5 div_y idle", div_y, 32'd1);

    // Flush blocks a request in IDLE; stray complete ignored
    flush = 1'b1; req_valid = 1'b1; req_x = 32'd8; req_y = 32'd4;
    #1;
    chk("t6 flush blocks ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("t6 not accepted", 32'(div), 32'd0);
    div_complete = 1'b1;
    tick();
    div_complete = 1'b0;
    chk("t6 stray complete", 32'(res_valid), 32'd0);

    // Timeout
    issue(1'b0, 32'd77, 32'd7, 5'd2);
    serve(0, 32'd0, 32'd0, 32'd77, 32'd7, highs, op_err);
    chk("t7 div high cycles", highs, 32'd34);
    chk("t7 res_valid", 32'(res_valid), 32'd1);
    chk("t7 res_timeout", 32'(res_timeout), 32'd1);
    chk("t7 res_s", res_s, 32'd0);
    chk("t7 res_r", res_r, 32'd0);
    chk("t7 res_tag", 32'(res_tag), 32'd2);
    tick();
    issue(1'b0, 32'd77, 32'd7, 5'd2);
    serve(4, 32'd11, 32'd0, 32'd77, 32'd7, highs, op_err);
    chk("t7 next highs", highs, 32'd4);
    chk("t7 next res_s", res_s, 32'd11);
    chk("t7 next timeout", 32'(res_timeout), 32'd0);
    tick();

    // Reset mid-RUN
    issue(1'b0, 32'd30, 32'd4, 5'd9);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t8 div after reset", 32'(div), 32'd0);
    chk("t8 no result", 32'(res_valid), 32'd0);
    chk("t8 div_x reset", div_x, 32'd0);
    tick();
    chk("t8 req_ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
